// File: rtl/cache_bus_arbiter_if.sv
// Signal bundle between NUM_PORTS upstream cache ports (s_*) and the single
// downstream bridge data port (m_*). The arbiter takes the master view.
interface cache_bus_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WORDS = 4
);
    logic [NUM_PORTS-1:0]               s_rd_req;
    logic [3*NUM_PORTS-1:0]             s_rd_type;
    logic [32*NUM_PORTS-1:0]            s_rd_addr;
    logic [NUM_PORTS-1:0]               s_rd_rdy;
    logic [NUM_PORTS-1:0]               s_ret_valid;
    logic [NUM_PORTS-1:0]               s_ret_last;
    logic [32*NUM_PORTS-1:0]            s_ret_data;

    logic [NUM_PORTS-1:0]               s_wr_req;
    logic [3*NUM_PORTS-1:0]             s_wr_type;
    logic [32*NUM_PORTS-1:0]            s_wr_addr;
    logic [4*NUM_PORTS-1:0]             s_wr_wstrb;
    logic [32*LINE_WORDS*NUM_PORTS-1:0] s_wr_data;
    logic [NUM_PORTS-1:0]               s_wr_rdy;

    logic                               m_rd_req;
    logic [2:0]                         m_rd_type;
    logic [31:0]                        m_rd_addr;
    logic                               m_rd_rdy;
    logic                               m_ret_valid;
    logic                               m_ret_last;
    logic [31:0]                        m_ret_data;

    logic                               m_wr_req;
    logic [2:0]                         m_wr_type;
    logic [31:0]                        m_wr_addr;
    logic [3:0]                         m_wr_wstrb;
    logic [32*LINE_WORDS-1:0]           m_wr_data;
    logic                               m_wr_rdy;

    logic                               err_stray_ret;

    modport master (
        input  s_rd_req, s_rd_type, s_rd_addr,
        output s_rd_rdy, s_ret_valid, s_ret_last, s_ret_data,
        input  s_wr_req, s_wr_type, s_wr_addr, s_wr_wstrb, s_wr_data,
        output s_wr_rdy,
        output m_rd_req, m_rd_type, m_rd_addr,
        input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        output m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
        input  m_wr_rdy,
        output err_stray_ret
    );

    modport slave (
        output s_rd_req, s_rd_type, s_rd_addr,
        input  s_rd_rdy, s_ret_valid, s_ret_last, s_ret_data,
        output s_wr_req, s_wr_type, s_wr_addr, s_wr_wstrb, s_wr_data,
        input  s_wr_rdy,
        input  m_rd_req, m_rd_type, m_rd_addr,
        output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        input  m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
        output m_wr_rdy,
        input  err_stray_ret
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin N-port arbiter merging cache read/write requests onto one bridge
// port. Reads own the return channel until the last beat; writes arbitrate independently.
module cache_bus_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                clock,
    input  logic                reset,
    cache_bus_arbiter_if.master bus
);
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int LINE_W = 32 * LINE_WORDS;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_RET  = 2'd2;
    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_REQ  = 1'b1;

    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    logic [1:0]       rd_st_q, rd_st_d;
    logic [PTR_W-1:0] rd_gnt_q, rd_gnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [0:0]       wr_st_q, wr_st_d;
    logic [PTR_W-1:0] wr_gnt_q, wr_gnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             err_q, err_d;
    int               rd_sel, wr_sel;

    // First requester at or after ptr, scanning cyclically.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PTR_W-1:0]     ptr);
        logic [PTR_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (req[idx]) pick = PTR_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PORT) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_sel = int'(rd_gnt_q);
    assign wr_sel = int'(wr_gnt_q);

    assign bus.err_stray_ret = err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        rd_st_d         = rd_st_q;
        rd_gnt_d        = rd_gnt_q;
        rd_ptr_d        = rd_ptr_q;
        err_d           = err_q;
        bus.s_rd_rdy    = '0;
        bus.s_ret_valid = '0;
        bus.s_ret_last  = '0;
        bus.s_ret_data  = '0;
        bus.m_rd_req    = 1'b0;
        bus.m_rd_type   = '0;
        bus.m_rd_addr   = '0;

        case (rd_st_q)
            RD_IDLE: begin
                if (|bus.s_rd_req) begin
                    rd_gnt_d = rr_pick(bus.s_rd_req, rd_ptr_q);
                    rd_st_d  = RD_REQ;
                end
            end
            RD_REQ: begin
                bus.m_rd_req         = bus.s_rd_req[rd_sel];
                bus.m_rd_type        = bus.s_rd_type[3*rd_sel +: 3];
                bus.m_rd_addr        = bus.s_rd_addr[32*rd_sel +: 32];
                bus.s_rd_rdy[rd_sel] = bus.m_rd_rdy;
                if (bus.s_rd_req[rd_sel] && bus.m_rd_rdy) begin
                    rd_st_d = RD_RET;
                end else if (!bus.s_rd_req[rd_sel]) begin
                    rd_st_d = RD_IDLE;
                end
            end
            RD_RET: begin
                // Burst length is not tracked; the bridge's last flag ends ownership.
                bus.s_ret_valid[rd_sel]         = bus.m_ret_valid;
                bus.s_ret_last[rd_sel]          = bus.m_ret_last;
                bus.s_ret_data[32*rd_sel +: 32] = bus.m_ret_data;
                if (bus.m_ret_valid && bus.m_ret_last) begin
                    rd_st_d  = RD_IDLE;
                    rd_ptr_d = ptr_inc(rd_gnt_q);
                end
            end
            default: rd_st_d = RD_IDLE;
        endcase

        if (bus.m_ret_valid && (rd_st_q != RD_RET)) err_d = 1'b1;
    end

    always_comb begin
        wr_st_d        = wr_st_q;
        wr_gnt_d       = wr_gnt_q;
        wr_ptr_d       = wr_ptr_q;
        bus.s_wr_rdy   = '0;
        bus.m_wr_req   = 1'b0;
        bus.m_wr_type  = '0;
        bus.m_wr_addr  = '0;
        bus.m_wr_wstrb = '0;
        bus.m_wr_data  = '0;

        case (wr_st_q)
            WR_IDLE: begin
                if (|bus.s_wr_req) begin
                    wr_gnt_d = rr_pick(bus.s_wr_req, wr_ptr_q);
                    wr_st_d  = WR_REQ;
                end
            end
            WR_REQ: begin
                bus.m_wr_req         = bus.s_wr_req[wr_sel];
                bus.m_wr_type        = bus.s_wr_type[3*wr_sel +: 3];
                bus.m_wr_addr        = bus.s_wr_addr[32*wr_sel +: 32];
                bus.m_wr_wstrb       = bus.s_wr_wstrb[4*wr_sel +: 4];
                bus.m_wr_data        = bus.s_wr_data[LINE_W*wr_sel +: LINE_W];
                bus.s_wr_rdy[wr_sel] = bus.m_wr_rdy;
                if (bus.s_wr_req[wr_sel] && bus.m_wr_rdy) begin
                    wr_st_d  = WR_IDLE;
                    wr_ptr_d = ptr_inc(wr_gnt_q);
                end else if (!bus.s_wr_req[wr_sel]) begin
                    wr_st_d = WR_IDLE;
                end
            end
            default: wr_st_d = WR_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments only; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_st_q  <= RD_IDLE;
            rd_gnt_q <= '0;
            rd_ptr_q <= '0;
            wr_st_q  <= WR_IDLE;
            wr_gnt_q <= '0;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_st_q  <= rd_st_d;
            rd_gnt_q <= rd_gnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_st_q  <= wr_st_d;
            wr_gnt_q <= wr_gnt_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed and randomized checks of cache_bus_arbiter (3 ports, 4-word lines)
// against a transaction-level round-robin model.
module tb_cache_bus_arbiter;
    localparam int NP = 3;
    localparam int LW = 4;
    localparam int DW = 32 * LW;

    logic clock;
    logic reset;

    cache_bus_arbiter_if #(.NUM_PORTS(NP), .LINE_WORDS(LW)) bus ();

    cache_bus_arbiter #(.NUM_PORTS(NP), .LINE_WORDS(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: round-robin pointers and the sticky stray flag.
    int   m_rd_ptr;
    int   m_wr_ptr;
    logic m_err;

    logic [31:0]   rd_addr_a [NP];
    logic [2:0]    rd_type_a [NP];
    logic [31:0]   wr_addr_a [NP];
    logic [2:0]    wr_type_a [NP];
    logic [3:0]    wr_strb_a [NP];
    logic [DW-1:0] wr_data_a [NP];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NP-1:0] mask, input int ptr);
        for (int k = 0; k < NP; k++) begin
            if (mask[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    task automatic rand_rd_payload(input int nbeats);
        for (int p = 0; p < NP; p++) begin
            rd_addr_a[p] = $urandom;
            rd_type_a[p] = (nbeats == 1) ? 3'($urandom_range(0, 2)) : 3'd4;
        end
    endtask

    task automatic rand_wr_payload;
        for (int p = 0; p < NP; p++) begin
            wr_addr_a[p] = $urandom;
            wr_type_a[p] = 3'($urandom_range(0, 7));
            wr_strb_a[p] = 4'($urandom);
            wr_data_a[p] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic apply_payload;
        for (int p = 0; p < NP; p++) begin
            bus.s_rd_addr[32*p +: 32]  = rd_addr_a[p];
            bus.s_rd_type[3*p +: 3]    = rd_type_a[p];
            bus.s_wr_addr[32*p +: 32]  = wr_addr_a[p];
            bus.s_wr_type[3*p +: 3]    = wr_type_a[p];
            bus.s_wr_wstrb[4*p +: 4]   = wr_strb_a[p];
            bus.s_wr_data[DW*p +: DW]  = wr_data_a[p];
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {bus.s_rd_rdy, bus.s_ret_valid, bus.s_ret_last, bus.s_wr_rdy,
                              bus.m_rd_req, bus.m_wr_req, bus.err_stray_ret}, '0);
        check({tag, "_addr"}, {bus.m_rd_type, bus.m_rd_addr, bus.m_wr_type, bus.m_wr_addr,
                               bus.m_wr_wstrb}, '0);
        check({tag, "_ret_data"}, bus.s_ret_data, '0);
        check({tag, "_wr_data"}, bus.m_wr_data, '0);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick;
        tick;
        settle;
        check_quiet("reset");
        reset = 1'b0;
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_err    = 1'b0;
    endtask

    // Entered while the read FSM is idle; leaves it idle again.
    task automatic do_read(input logic [NP-1:0] mask, input int nbeats, input int rdy_gap,
                           input int beat_gap, input bit keep, input bit directed);
        int              w;
        logic [31:0]     d;
        logic [32*NP-1:0] exp_data;
        logic [NP-1:0]   onehot;
        w      = rr(mask, m_rd_ptr);
        onehot = NP'(1) << w;
        apply_payload;
        bus.s_rd_req = mask;
        bus.m_rd_rdy = 1'b0;
        settle;
        check("rd_idle_quiet", bus.m_rd_req, 1'b0);
        tick;
        settle;
        check("rd_req", bus.m_rd_req, 1'b1);
        check("rd_addr", bus.m_rd_addr, rd_addr_a[w]);
        check("rd_type", bus.m_rd_type, rd_type_a[w]);
        check("rd_rdy_wait", bus.s_rd_rdy, '0);
        for (int i = 0; i < rdy_gap; i++) begin
            tick;
            settle;
            check("rd_rdy_wait", bus.s_rd_rdy, '0);
        end
        bus.m_rd_rdy = 1'b1;
        settle;
        check("rd_accept", bus.s_rd_rdy, onehot);
        tick;
        bus.m_rd_rdy = 1'b0;
        if (!keep) bus.s_rd_req[w] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < beat_gap; g++) begin
                bus.m_ret_valid = 1'b0;
                bus.m_ret_last  = 1'b0;
                settle;
                check("ret_gap", bus.s_ret_valid, '0);
                tick;
            end
            d = directed ? (32'hA0 + 32'(b)) : $urandom;
            bus.m_ret_valid = 1'b1;
            bus.m_ret_last  = (b == nbeats - 1);
            bus.m_ret_data  = d;
            settle;
            exp_data = '0;
            exp_data[32*w +: 32] = d;
            check("ret_valid", bus.s_ret_valid, onehot);
            check("ret_last", bus.s_ret_last, (b == nbeats - 1) ? onehot : '0);
            check("ret_data", bus.s_ret_data, exp_data);
            check("rd_rdy_busy", bus.s_rd_rdy, '0);
            tick;
        end
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        bus.m_ret_data  = '0;
        bus.s_rd_req    = '0;
        m_rd_ptr = (w + 1) % NP;
        settle;
        check("err_flag", bus.err_stray_ret, m_err);
    endtask

    // Entered while the write FSM is idle; leaves it idle again.
    task automatic do_write(input logic [NP-1:0] mask, input int rdy_gap);
        int            w;
        logic [NP-1:0] onehot;
        w      = rr(mask, m_wr_ptr);
        onehot = NP'(1) << w;
        apply_payload;
        bus.s_wr_req = mask;
        bus.m_wr_rdy = 1'b0;
        settle;
        check("wr_idle_quiet", bus.m_wr_req, 1'b0);
        tick;
        settle;
        check("wr_req", bus.m_wr_req, 1'b1);
        check("wr_addr", bus.m_wr_addr, wr_addr_a[w]);
        check("wr_type", bus.m_wr_type, wr_type_a[w]);
        check("wr_wstrb", bus.m_wr_wstrb, wr_strb_a[w]);
        check("wr_data", bus.m_wr_data, wr_data_a[w]);
        check("wr_rdy_wait", bus.s_wr_rdy, '0);
        for (int i = 0; i < rdy_gap; i++) begin
            tick;
            settle;
            check("wr_rdy_wait", bus.s_wr_rdy, '0);
        end
        bus.m_wr_rdy = 1'b1;
        settle;
        check("wr_accept", bus.s_wr_rdy, onehot);
        tick;
        bus.m_wr_rdy = 1'b0;
        bus.s_wr_req = '0;
        m_wr_ptr = (w + 1) % NP;
    endtask

    initial begin
        int               rw;
        int               ww;
        int               nb;
        logic [31:0]      d;
        logic [32*NP-1:0] exp_data;

        reset           = 1'b1;
        bus.s_rd_req    = '1;
        bus.s_wr_req    = '1;
        bus.s_rd_type   = '0;
        bus.s_rd_addr   = '0;
        bus.s_wr_type   = '0;
        bus.s_wr_addr   = '0;
        bus.s_wr_wstrb  = '0;
        bus.s_wr_data   = '0;
        bus.m_rd_rdy    = 1'b0;
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        bus.m_ret_data  = '0;
        bus.m_wr_rdy    = 1'b0;
        rand_rd_payload(4);
        rand_wr_payload;
        apply_payload;
        pulse_reset;
        bus.s_rd_req = '0;
        bus.s_wr_req = '0;
        tick;

        // Port 0 line read with the fixed A0..A3 beat pattern.
        rand_rd_payload(4);
        rd_addr_a[0] = 32'h0000_1000;
        rd_type_a[0] = 3'd4;
        do_read(3'b001, 4, 0, 0, 1'b0, 1'b1);

        // Port 1 drops its request before acceptance: pointer must not move.
        rand_rd_payload(4);
        apply_payload;
        bus.s_rd_req = 3'b010;
        tick;
        settle;
        check("drop_req", bus.m_rd_req, 1'b1);
        bus.s_rd_req = '0;
        settle;
        check("drop_req_low", bus.m_rd_req, 1'b0);
        check("drop_rdy", bus.s_rd_rdy, '0);
        tick;
        rand_rd_payload(4);
        do_read(3'b011, 4, 1, 0, 1'b0, 1'b0);

        // Two ports holding requests continuously alternate.
        for (int i = 0; i < 4; i++) begin
            rand_rd_payload(4);
            do_read(3'b011, 4, i % 2, 1, 1'b1, 1'b0);
        end

        // All three ports write: 0,1,2,0 with the line forwarded unmodified.
        rand_wr_payload;
        wr_data_a[0] = 128'hDEADBEEF_0BADF00D_CAFEF00D_01234567;
        do_write(3'b111, 0);
        for (int i = 0; i < 3; i++) begin
            rand_wr_payload;
            do_write(3'b111, 0);
        end

        // Port 0 write accepted in the middle of a port 1 read burst.
        rand_rd_payload(4);
        rand_wr_payload;
        wr_addr_a[0] = 32'h0000_2000;
        apply_payload;
        rw = rr(3'b010, m_rd_ptr);
        ww = rr(3'b001, m_wr_ptr);
        bus.s_rd_req = 3'b010;
        bus.s_wr_req = 3'b001;
        tick;
        bus.m_rd_rdy = 1'b1;
        settle;
        check("cc_rd_accept", bus.s_rd_rdy, 3'b010);
        check("cc_wr_req", bus.m_wr_req, 1'b1);
        check("cc_wr_addr", bus.m_wr_addr, 32'h0000_2000);
        tick;
        bus.m_rd_rdy = 1'b0;
        bus.s_rd_req = '0;
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            bus.m_ret_valid = 1'b1;
            bus.m_ret_last  = (b == 3);
            bus.m_ret_data  = d;
            if (b == 1) bus.m_wr_rdy = 1'b1;
            settle;
            exp_data = '0;
            exp_data[32*rw +: 32] = d;
            check("cc_ret_valid", bus.s_ret_valid, 3'b010);
            check("cc_ret_data", bus.s_ret_data, exp_data);
            if (b == 1) check("cc_wr_accept", bus.s_wr_rdy, 3'b001);
            tick;
            if (b == 1) begin
                bus.m_wr_rdy = 1'b0;
                bus.s_wr_req = '0;
            end
        end
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        m_rd_ptr = (rw + 1) % NP;
        m_wr_ptr = (ww + 1) % NP;

        // Stray beat while idle is dropped and latches the error flag.
        bus.m_ret_valid = 1'b1;
        bus.m_ret_last  = 1'b1;
        bus.m_ret_data  = $urandom;
        settle;
        check("stray_drop", {bus.s_ret_valid, bus.s_ret_last}, '0);
        check("stray_data", bus.s_ret_data, '0);
        tick;
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        m_err = 1'b1;
        settle;
        check("stray_err", bus.err_stray_ret, m_err);
        tick;
        rand_rd_payload(1);
        do_read(3'b001, 1, 0, 0, 1'b0, 1'b0);

        // Reset two beats into a port 1 burst; leftover beats become strays.
        rand_rd_payload(4);
        apply_payload;
        bus.s_rd_req = 3'b010;
        tick;
        bus.m_rd_rdy = 1'b1;
        settle;
        check("mid_accept", bus.s_rd_rdy, 3'b010);
        tick;
        bus.m_rd_rdy = 1'b0;
        bus.s_rd_req = '0;
        for (int b = 0; b < 2; b++) begin
            bus.m_ret_valid = 1'b1;
            bus.m_ret_data  = $urandom;
            settle;
            check("mid_beat", bus.s_ret_valid, 3'b010);
            tick;
        end
        bus.m_ret_valid = 1'b0;
        reset = 1'b1;
        tick;
        settle;
        check_quiet("mid_rst");
        reset    = 1'b0;
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_err    = 1'b0;
        for (int b = 2; b < 4; b++) begin
            bus.m_ret_valid = 1'b1;
            bus.m_ret_last  = (b == 3);
            bus.m_ret_data  = $urandom;
            settle;
            check("post_rst_stray", bus.s_ret_valid, '0);
            tick;
        end
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        m_err = 1'b1;
        settle;
        check("post_rst_err", bus.err_stray_ret, m_err);
        rand_rd_payload(4);
        do_read(3'b101, 4, 0, 0, 1'b0, 1'b0);
        rand_wr_payload;
        do_write(3'b101, 0);
        pulse_reset;
        tick;

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                nb = ($urandom_range(0, 1) == 0) ? 1 : LW;
                rand_rd_payload(nb);
                do_read(NP'($urandom_range(1, 7)), nb, $urandom_range(0, 2),
                        $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                rand_wr_payload;
                do_write(NP'($urandom_range(1, 7)), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Parametrised N-port arbiter that merges the cache-side read and write request interfaces of NUM_PORTS caches onto the single data-port cache interface of axi_bridge.
- Examples of requesters: icache, dcache, a future L2 or prefetcher.
- Replaces the fixed two-client inst/data split. Adds round-robin fairness, line-granular read ownership, and an independent write arbiter.

Parameters:
- NUM_PORTS, 2, number of upstream cache ports (≥2).
- LINE_WORDS, 4, 32-bit words per cache line; wr_data width is 32*LINE_WORDS.
- PTR_W, $clog2(NUM_PORTS), grant index width (derived; do not override).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_rd_req  in  NUM_PORTS  per-port read request
- s_rd_type  in  3*NUM_PORTS  per-port read type, port i at [3i+:3]
- s_rd_addr  in  32*NUM_PORTS  per-port read address
- s_rd_rdy  out  NUM_PORTS  read accepted (one-hot or zero)
- s_ret_valid  out  NUM_PORTS  return beat valid, owner port only
- s_ret_last  out  NUM_PORTS  last return beat, owner port only
- s_ret_data  out  32*NUM_PORTS  return data, owner slice only; other slices 0
- s_wr_req  in  NUM_PORTS  per-port write request
- s_wr_type  in  3*NUM_PORTS  write type
- s_wr_addr  in  32*NUM_PORTS  write address
- s_wr_wstrb  in  4*NUM_PORTS  write byte strobe
- s_wr_data  in  32*LINE_WORDS*NUM_PORTS  write line data
- s_wr_rdy  out  NUM_PORTS  write accepted (one-hot or zero)
- m_rd_req / m_rd_type / m_rd_addr  out  1/3/32  downstream read request
- m_rd_rdy  in  1  downstream read accept
- m_ret_valid / m_ret_last / m_ret_data  in  1/1/32  downstream return beat
- m_wr_req / m_wr_type / m_wr_addr / m_wr_wstrb / m_wr_data  out  1/3/32/4/32*LINE_WORDS  downstream write
- m_wr_rdy  in  1  downstream write accept
- err_stray_ret  out  1  sticky: return beat arrived with no read owner

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- Reset state:
  - All outputs 0.
  - Read FSM = RD_IDLE, write FSM = WR_IDLE.
  - rd_ptr = 0, wr_ptr = 0, err_stray_ret = 0.
- Read FSM:
  - RD_IDLE: if any s_rd_req, choose the first requesting port at or after rd_ptr (cyclic). Latch it as rd_gnt and go to RD_REQ next cycle. Nothing is driven downstream in RD_IDLE.
  - RD_REQ: m_rd_req/type/addr are driven combinationally from port rd_gnt. s_rd_rdy[rd_gnt] = m_rd_rdy.
    - On m_rd_req && m_rd_rdy: go to RD_RET.
    - If s_rd_req[rd_gnt] drops before acceptance (protocol violation tolerated): go to RD_IDLE with no pointer change.
  - RD_RET: route m_ret_valid/last/data to port rd_gnt only.
    - On m_ret_valid && m_ret_last: go to RD_IDLE and set rd_ptr = (rd_gnt+1) mod NUM_PORTS.
    - rd_type 0..2 (uncached single beat) ends on its single last beat; line reads end after LINE_WORDS beats, detected by last only.
  - Exactly one outstanding read. Other ports see s_rd_rdy = 0 until release.
  - Minimum latency: request seen at cycle t → m_rd_req at t+1.
- Write FSM (independent of reads, may run the same cycle):
  - WR_IDLE: round-robin pick from wr_ptr, latch wr_gnt, go to WR_REQ.
  - WR_REQ: m_wr_* driven from port wr_gnt; s_wr_rdy[wr_gnt] = m_wr_rdy.
    - On handshake: go to WR_IDLE and set wr_ptr = wr_gnt+1.
    - On request drop: go to WR_IDLE.
  - Writes complete on handshake; no response channel.
- Stray return: m_ret_valid outside RD_RET is dropped (no s_ret_valid asserted) and sets err_stray_ret. It is cleared only by reset.
- Reset mid-burst: the transaction is abandoned and any remaining beats are later flagged as stray. The bench must drain the downstream side before reuse.
- Pointer wrap: (NUM_PORTS-1)+1 → 0. A non-power-of-two NUM_PORTS must wrap correctly (e.g. 3 ports: 2 → 0).
- Fairness: a port that keeps re-requesting cannot win twice in a row while another port is requesting.

Test Plan:
- Reset, then port0 read addr 0x0000_1000 type 4 → m_rd_req=1 one cycle after s_rd_req. Four beats 0xA0..0xA3 appear only on slice 0; s_ret_last[0] is on the 4th beat; FSM returns to RD_IDLE with rd_ptr=1.
- Ports 0 and 1 both hold read requests continuously → grant order 0,1,0,1. Neither port receives s_rd_rdy while the other's burst is outstanding.
- NUM_PORTS=3, all three request writes with m_wr_rdy=1 → accept order 0,1,2,0. wr_data of 128 bits is forwarded unmodified (0xDEADBEEF_…_01234567).
- Port1 line read in RD_RET while port0 writes 0x0000_2000 → write accepted during the read burst; read beats are unaffected.
- m_ret_valid pulsed in RD_IDLE → no s_ret_valid asserted; err_stray_ret=1 and it stays set until reset.
- Reset asserted at beat 2 of 4 → all outputs 0 the next cycle, FSMs idle, pointers 0. Remaining beats set err_stray_ret.
